// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one registered SIZE-bit adder shared round-robin by NREQ requesters.
// Each operation runs through IDLE -> EXEC -> DONE, one operation per three cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request level
//   a_in/b_in  packed operands, requester i at [i*SIZE +: SIZE]
//   grant      one-hot, requester whose operation is in flight
//   done       one-hot, one-cycle pulse when result is valid for that requester
//   result     registered sum (held between operations)
//   carry_out  unsigned carry of the sum
//   overflow   signed two's-complement overflow of the sum
//   busy       high whenever the sequencer is not idle
module adder_share_arbiter #(
  parameter int unsigned SIZE = 32,
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] a_in,
  input  logic [NREQ*SIZE-1:0] b_in,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [SIZE-1:0]      result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   win_q;
  logic [SIZE-1:0]   op_a_q;
  logic [SIZE-1:0]   op_b_q;

  logic [PtrW-1:0]   win_idx;
  logic              win_found;
  logic [PtrW:0]     cand;
  logic [SIZE-1:0]   a_sel;
  logic [SIZE-1:0]   b_sel;
  logic [SIZE:0]     sum;

  // Round-robin scan starting at rr_ptr; the extra bit on cand lets the wrap
  // happen at NREQ rather than at the next power of two.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (cand >= (PtrW+1)'(NREQ)) begin
        cand = cand - (PtrW+1)'(NREQ);
      end
      if (!win_found && req[cand[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == PtrW'(i)) begin
        a_sel = a_in[i*SIZE +: SIZE];
        b_sel = b_in[i*SIZE +: SIZE];
      end
    end
  end

  assign sum = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            win_q   <= win_idx;
            op_a_q  <= a_sel;
            op_b_q  <= b_sel;
            grant   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            busy    <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          result    <= sum[SIZE-1:0];
          carry_out <= sum[SIZE];
          overflow  <= (op_a_q[SIZE-1] == op_b_q[SIZE-1]) &&
                       (sum[SIZE-1] != op_a_q[SIZE-1]);
          done      <= grant;
          state_q   <= StDone;
        end
        StDone: begin
          done     <= '0;
          grant    <= '0;
          busy     <= 1'b0;
          rr_ptr_q <= (win_q == PtrW'(NREQ-1)) ? '0 : win_q + 1'b1;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          grant   <= '0;
          done    <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

  localparam int SIZE = 32;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] a_in;
  logic [NREQ*SIZE-1:0] b_in;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [SIZE-1:0]      result;
  logic                 carry_out;
  logic                 overflow;
  logic                 busy;

  logic [SIZE-1:0] a_v [NREQ];
  logic [SIZE-1:0] b_v [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  adder_share_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .grant     (grant),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*SIZE +: SIZE] = a_v[i];
      b_in[i*SIZE +: SIZE] = b_v[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // An operation is "in flight" for two cycles after the edge that picked it:
  // age 0 = adding, age 1 = result presented.
  bit              m_active;
  int              m_age;
  int              m_w;
  int              m_ptr;
  int              m_c;
  bit              m_found;
  logic [SIZE-1:0] m_a, m_b, m_res;
  bit              m_carry, m_ovf;
  longint unsigned m_us;
  longint          m_ss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_age = 0; m_w = 0; m_ptr = 0;
      m_a = '0; m_b = '0; m_res = '0; m_carry = 0; m_ovf = 0;
    end else begin
      cyc++;
      if (!m_active) begin
        m_found = 0;
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_ptr + k) % NREQ;
          if (!m_found && req[m_c]) begin
            m_found = 1;
            m_w     = m_c;
          end
        end
        if (m_found) begin
          m_a = a_v[m_w]; m_b = b_v[m_w];
          m_active = 1; m_age = 0;
        end
      end else if (m_age == 0) begin
        m_us    = longint'(m_a) + longint'(m_b);
        m_res   = m_us[SIZE-1:0];
        m_carry = (m_us >= 64'h1_0000_0000);
        m_ss    = longint'($signed(m_a)) + longint'($signed(m_b));
        m_ovf   = (m_ss > 64'sd2147483647) || (m_ss < -64'sd2147483648);
        m_age   = 1;
      end else begin
        m_active = 0;
        m_ptr    = (m_w + 1) % NREQ;
      end
    end
  end

  // ---------------- per-cycle compare + event logs ----------------
  logic [NREQ-1:0] exp_g, exp_d, one_hot, prev_grant;
  logic [NREQ-1:0] done_log [$];
  logic [NREQ-1:0] grant_log [$];
  int              done_cyc [$];
  logic [SIZE-1:0] done_res [$];

  always @(negedge clk) begin
    if (rst_n) begin
      one_hot = 1;
      one_hot = one_hot << m_w;
      exp_g   = m_active ? one_hot : '0;
      exp_d   = (m_active && m_age == 1) ? one_hot : '0;
      check("grant", 64'(grant), 64'(exp_g));
      check("done", 64'(done), 64'(exp_d));
      check("busy", 64'(busy), 64'(m_active));
      check("result", 64'(result), 64'(m_res));
      check("carry_out", 64'(carry_out), 64'(m_carry));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (done != 0) begin
        done_log.push_back(done);
        done_cyc.push_back(cyc);
        done_res.push_back(result);
      end
      if (grant != 0 && prev_grant == 0) grant_log.push_back(grant);
      prev_grant = grant;
    end else begin
      prev_grant = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (grant == 0 && n < 12) begin tick(); n++; end
    if (grant == 0) check({name, "_grant_timeout"}, 64'(grant), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done == 0 && n < 12) begin tick(); n++; end
    if (done == 0) check({name, "_done_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || grant != 0) && n < 12) begin tick(); n++; end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic corner(input string name, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [SIZE-1:0] r, input bit c, input bit o);
    wait_idle();
    a_v[2] = a; b_v[2] = b; req = 4'b0100;
    wait_grant(name);
    req = 0;
    wait_done(name);
    check({name, "_done"}, 64'(done), 64'h4);
    check({name, "_result"}, 64'(result), 64'(r));
    check({name, "_carry"}, 64'(carry_out), 64'(c));
    check({name, "_ovf"}, 64'(overflow), 64'(o));
  endtask

  initial begin
    rst_n = 0;
    req   = '0;
    for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
    #12;
    check("rst_grant", 64'(grant), 0);
    check("rst_done", 64'(done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_result", 64'(result), 0);
    check("rst_flags", 64'({carry_out, overflow}), 0);
    @(negedge clk);
    rst_n = 1;

    // Single operation, cycle by cycle.
    req = 4'b0001; a_v[0] = 5; b_v[0] = 7;
    tick();
    check("single_grant", 64'(grant), 64'h1);
    check("single_busy", 64'(busy), 1);
    req = 0;
    tick();
    check("single_done", 64'(done), 64'h1);
    check("single_result", 64'(result), 64'd12);
    check("single_flags", 64'({carry_out, overflow}), 0);
    tick();
    check("single_busy_low", 64'(busy), 0);
    check("single_grant_low", 64'(grant), 0);

    // Arithmetic corners.
    corner("c_carry", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1, 0);
    corner("c_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    corner("c_both", 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 1);

    // Withdrawal with operand change after grant.
    wait_idle();
    a_v[0] = 20; b_v[0] = 22; req = 4'b0001;
    wait_grant("wd");
    req = 0; a_v[0] = 999;
    wait_done("wd");
    check("wd_done", 64'(done), 64'h1);
    check("wd_result", 64'(result), 64'd42);

    // Reset during EXEC, then contention with req=1111 held from reset.
    wait_idle();
    a_v[2] = 1; b_v[2] = 2; req = 4'b0100;
    wait_grant("rst_op");
    #2 rst_n = 0;
    #1;
    check("midrst_grant", 64'(grant), 0);
    check("midrst_done", 64'(done), 0);
    check("midrst_busy", 64'(busy), 0);
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 32'h1000 * (i + 1);
      b_v[i] = i + 3;
    end
    req = 4'b1111;
    @(posedge clk);
    #3 rst_n = 1;
    done_log.delete(); done_cyc.delete(); done_res.delete();
    tick();
    check("post_rst_grant", 64'(grant), 64'h1);
    repeat (13) begin
      req = req & ~done;
      tick();
    end
    req = 0;
    check("cont_count", 64'(done_log.size()), 4);
    if (done_log.size() == 4) begin
      check("cont_d0", 64'(done_log[0]), 64'h1);
      check("cont_d1", 64'(done_log[1]), 64'h2);
      check("cont_d2", 64'(done_log[2]), 64'h4);
      check("cont_d3", 64'(done_log[3]), 64'h8);
      check("cont_r0", 64'(done_res[0]), 64'h1003);
      check("cont_r3", 64'(done_res[3]), 64'h4006);
      for (int i = 0; i < 3; i++) check("cont_gap", 64'(done_cyc[i+1] - done_cyc[i]), 3);
    end

    // Fairness: requesters 1 and 3 held continuously.
    wait_idle();
    grant_log.delete();
    req = 4'b1010;
    repeat (18) tick();
    req = 0;
    check("fair_count", 64'(grant_log.size() >= 6), 1);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      check("fair_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'h2 : 64'h8);

    // Randomized traffic against the model.
    wait_idle();
    repeat (400) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: a_v[i] = 32'hFFFF_FFFF;
          1: a_v[i] = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
          default: a_v[i] = $urandom;
        endcase
        b_v[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      tick();
    end
    req = 0;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered SIZE-bit adder between NREQ requesters in the MIPS_32 datapath, such as the PC-increment, branch-target and address-generation units.
- Arbitrates round-robin and captures the winner's operands.
- Sequences a fixed three-state operation and returns the sum with a one-cycle done pulse addressed to the winner.

Parameters:
SIZE, 32, operand/result width in bits
NREQ, 4, number of requesters (2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester operation request, level
a_in  input  NREQ*SIZE  operand A, requester i at bits [i*SIZE +: SIZE]
b_in  input  NREQ*SIZE  operand B, same packing
grant  output  NREQ  one-hot, requester whose operation is in flight
done  output  NREQ  one-hot one-cycle pulse, result valid for that requester
result  output  SIZE  registered sum, valid while done != 0
carry_out  output  1  unsigned carry of the sum, valid with done
overflow  output  1  signed two's-complement overflow, valid with done
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n). Reset forces immediately, without a clock edge:
  - state=IDLE, rr_ptr=0
  - grant=0, done=0, result=0, carry_out=0, overflow=0, busy=0
  - internal operand registers = 0
- States: IDLE, EXEC, DONE.
- IDLE:
  - If req==0, remain in IDLE with all outputs held at 0 except result, carry_out and overflow, which keep their last values.
  - If req!=0, pick the winner w = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - On that edge: latch a_in[w] and b_in[w] into op_a/op_b, set grant=onehot(w), set state=EXEC.
- EXEC:
  - result <= op_a + op_b truncated to SIZE bits (wraps mod 2^SIZE).
  - carry_out <= bit SIZE of the (SIZE+1)-bit sum.
  - overflow <= (op_a[MSB]==op_b[MSB]) && (sum[MSB]!=op_a[MSB]).
  - done <= grant; state=DONE.
  - req and a_in/b_in are ignored in this state.
- DONE:
  - done visible for exactly this cycle; grant still high.
  - On the next edge: done=0, grant=0, rr_ptr=(w+1) mod NREQ, state=IDLE.
- Timing:
  - Latency: req sampled at edge N; grant visible after edge N; done/result visible after edge N+1; busy falls after edge N+2.
  - Throughput: one operation per 3 cycles. The earliest next arbitration is at edge N+3.
- Requester contract:
  - Hold req and operands stable until grant is seen.
  - Deassert req by the first edge after done if no further operation is wanted. Req still high when IDLE samples it is a new request.
- Boundary conditions:
  - req withdrawn after grant: the operation still completes and done still pulses (operands already captured).
  - Operands changing after grant: no effect on the result.
  - Simultaneous requests: exactly one grant. The others wait, and no request is lost while held.
  - Fairness: a continuously asserted requester is served within NREQ operations.
  - rst_n asserted in EXEC or DONE: the operation is aborted with no done pulse. After release the block starts in IDLE with rr_ptr=0.
  - grant and done are never multi-hot. done is never asserted without grant.
  - NREQ not a power of two: rr_ptr wraps from NREQ-1 to 0, never to unused indices.

Test Plan:
- Single operation: after reset, req=4'b0001, a_in[0]=5, b_in[0]=7 for one cycle. Expect grant=0001 after edge 1, done=0001 with result=12, carry_out=0 and overflow=0 after edge 2, busy=0 after edge 3.
- Arithmetic corners via requester 2:
  - 0xFFFFFFFF+0x00000001 -> result 0, carry_out 1, overflow 0.
  - 0x7FFFFFFF+0x00000001 -> 0x80000000, carry_out 0, overflow 1.
  - 0x80000000+0x80000000 -> 0, carry_out 1, overflow 1.
- Contention: req=1111 held from reset, each requester dropping req after its done. Expect done order 0001, 0010, 0100, 1000, spaced 3 cycles apart, each with that requester's sum.
- Fairness: req[1] and req[3] held continuously. Expect grant order 0010, 1000, 0010, 1000...; requesters 0 and 2 are never granted.
- Withdrawal: req[0] asserted, dropped and a_in[0] changed in the cycle after grant. Expect done=0001 with the sum of the originally captured operands.
- Reset mid-operation: rst_n low during EXEC. Expect grant, done and busy at 0 immediately, with no done pulse. After release with req=1111, expect the first grant to be 0001.
